// File: rtl/rename_pkg.sv
// Shared sizing, free-list pointer type and pointer arithmetic for the
// rename-stage free list and its checkpoint table.
package rename_pkg;

  localparam int DEF_DISPATCH_W = 4;
  localparam int DEF_COMMIT_W   = 4;
  localparam int DEF_NUM_PHYS   = 96;
  localparam int DEF_NUM_ARCH   = 32;
  localparam int DEF_NUM_CKPT   = 8;

  localparam int FL_DEPTH = DEF_NUM_PHYS - DEF_NUM_ARCH;
  localparam int PHYS_W   = $clog2(DEF_NUM_PHYS);
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int CKPT_W   = $clog2(DEF_NUM_CKPT);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  // Circular pointer: index wraps at FL_DEPTH and toggles phase on wrap.
  typedef struct packed {
    logic                phase;
    logic [FL_IDX_W-1:0] idx;
  } fl_ptr_t;

  // Advance a pointer by n (n <= FL_DEPTH).
  function automatic fl_ptr_t ptr_add(fl_ptr_t p, logic [CNT_W-1:0] n);
    fl_ptr_t r;
    int      s;
    s = int'(p.idx) + int'(n);
    r = p;
    if (s >= FL_DEPTH) begin
      r.idx   = FL_IDX_W'(s - FL_DEPTH);
      r.phase = ~p.phase;
    end else begin
      r.idx = FL_IDX_W'(s);
    end
    return r;
  endfunction

  // Distance a - b in entries, resolved by phase.
  function automatic logic [CNT_W-1:0] ptr_diff(fl_ptr_t a, fl_ptr_t b);
    int d;
    if (a.phase == b.phase) d = int'(a.idx) - int'(b.idx);
    else                    d = int'(a.idx) + FL_DEPTH - int'(b.idx);
    return CNT_W'(d);
  endfunction

endpackage

// File: rtl/fl_ckpt_table.sv
// Head checkpoint table: saved head pointers, free-slot mask, lowest-free
// slot selection, release-mask and restore handling.
module fl_ckpt_table
  import rename_pkg::*;
#(
  parameter int NUM_CKPT = DEF_NUM_CKPT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear_all,
  input  logic                alloc,
  input  fl_ptr_t             alloc_head,
  output logic [CKPT_W-1:0]   alloc_id,
  output logic                full,
  input  logic [NUM_CKPT-1:0] release_mask,
  input  logic                restore,
  input  logic [CKPT_W-1:0]   restore_id,
  output fl_ptr_t             restore_head,
  output logic                restore_valid
);

  logic [NUM_CKPT-1:0] free_reg;
  logic [NUM_CKPT-1:0] free_next;
  fl_ptr_t             heads [NUM_CKPT];
  logic                found;

  // Lowest free slot wins; slots released this cycle are not yet visible.
  always_comb begin
    alloc_id = '0;
    found    = 1'b0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      if (free_reg[i] && !found) begin
        alloc_id = CKPT_W'(i);
        found    = 1'b1;
      end
    end
  end

  assign full          = ~|free_reg;
  assign restore_head  = heads[restore_id];
  assign restore_valid = restore && (int'(restore_id) < NUM_CKPT) && !free_reg[restore_id];

  // Next free mask: flush frees all, otherwise apply release, restore, grant.
  always_comb begin
    free_next = free_reg;
    if (clear_all) begin
      free_next = '1;
    end else begin
      free_next = free_reg | release_mask;
      if (restore_valid) free_next[restore_id] = 1'b1;
      if (alloc)         free_next[alloc_id]   = 1'b0;
    end
  end

  // Free mask register.
  always_ff @(posedge clk) begin
    if (reset) free_reg <= '1;
    else       free_reg <= free_next;
  end

  // Capture the post-allocation head into the granted slot.
  always_ff @(posedge clk) begin
    if (alloc) heads[alloc_id] <= alloc_head;
  end

endmodule

// File: rtl/ckpt_free_list.sv
// Speculative physical-register free list with head checkpoints.
// Optional build macro FREELIST_STATS_EN adds stall/restore statistics ports.
module ckpt_free_list
  import rename_pkg::*;
#(
  parameter int DISPATCH_W = DEF_DISPATCH_W,
  parameter int COMMIT_W   = DEF_COMMIT_W,
  parameter int NUM_PHYS   = DEF_NUM_PHYS,
  parameter int NUM_ARCH   = DEF_NUM_ARCH,
  parameter int NUM_CKPT   = DEF_NUM_CKPT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall_i,
  input  logic [DISPATCH_W-1:0]        alloc_req_i,
  output logic [DISPATCH_W*PHYS_W-1:0] alloc_tag_o,
  output logic                         alloc_ok_o,
  output logic                         empty_o,
  input  logic [COMMIT_W-1:0]          commit_valid_i,
  input  logic [COMMIT_W*PHYS_W-1:0]   commit_tag_i,
  input  logic                         ckpt_req_i,
  output logic [CKPT_W-1:0]            ckpt_id_o,
  output logic                         ckpt_ok_o,
  output logic                         ckpt_full_o,
  input  logic                         restore_i,
  input  logic [CKPT_W-1:0]            restore_id_i,
  input  logic [NUM_CKPT-1:0]          ckpt_release_i,
  input  logic                         recover_i,
`ifdef FREELIST_STATS_EN
  output logic [31:0]                  stall_cycles_o,
  output logic [15:0]                  restore_cnt_o,
`endif
  output logic                         overflow_o
);

  localparam int DEPTH = NUM_PHYS - NUM_ARCH;

  fl_ptr_t           head_reg, head_next;
  fl_ptr_t           tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              overflow_reg, overflow_next;
  logic [PHYS_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0]  alloc_off [DISPATCH_W];
  logic [CNT_W-1:0]  push_off  [COMMIT_W];
  logic [CNT_W-1:0]  alloc_total, push_cnt, pop_cnt;
  fl_ptr_t           rd_ptr [DISPATCH_W];
  fl_ptr_t           wr_ptr [COMMIT_W];
  int                sum;

  fl_ptr_t           restore_head;
  logic              restore_valid;
  logic              ckpt_full;

  // Compacted lane offsets: each lane skips the requesters below it.
  always_comb begin
    alloc_total = '0;
    push_cnt    = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      alloc_off[k] = '0;
      for (int j = 0; j < k; j++) alloc_off[k] += CNT_W'(alloc_req_i[j]);
      rd_ptr[k]    = ptr_add(head_reg, alloc_off[k]);
      alloc_total += CNT_W'(alloc_req_i[k]);
    end
    for (int k = 0; k < COMMIT_W; k++) begin
      push_off[k] = '0;
      for (int j = 0; j < k; j++) push_off[k] += CNT_W'(commit_valid_i[j]);
      wr_ptr[k]  = ptr_add(tail_reg, push_off[k]);
      push_cnt  += CNT_W'(commit_valid_i[k]);
    end
  end

  assign empty_o    = count_reg < CNT_W'(DISPATCH_W);
  assign alloc_ok_o = (|alloc_req_i) && !empty_o && !stall_i && !restore_i && !recover_i;
  assign pop_cnt    = alloc_ok_o ? alloc_total : '0;
  assign ckpt_ok_o  = ckpt_req_i && !ckpt_full && !restore_i && !recover_i;
  assign ckpt_full_o = ckpt_full;
  assign overflow_o = overflow_reg;

  for (genvar gi = 0; gi < DISPATCH_W; gi++) begin : g_tag
    assign alloc_tag_o[gi*PHYS_W +: PHYS_W] = alloc_req_i[gi] ? mem[rd_ptr[gi].idx] : '0;
  end

  // Pointer/count update: recover, then restore, then normal alloc/push.
  always_comb begin
    tail_next     = ptr_add(tail_reg, push_cnt);
    head_next     = head_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    sum           = 0;
    if (recover_i) begin
      head_next  = tail_next;
      count_next = CNT_W'(DEPTH);
    end else if (restore_valid) begin
      // Head runs ahead of tail by the number of entries in flight.
      head_next  = restore_head;
      count_next = CNT_W'(DEPTH) - ptr_diff(restore_head, tail_next);
    end else begin
      head_next = ptr_add(head_reg, pop_cnt);
      sum = int'(count_reg) - int'(pop_cnt) + int'(push_cnt);
      if (sum > DEPTH) begin
        overflow_next = 1'b1;
        count_next    = CNT_W'(DEPTH);
      end else begin
        count_next = CNT_W'(sum);
      end
    end
  end

  // Pointer, count and overflow state.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= CNT_W'(DEPTH);
      overflow_reg <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Tag storage: reset to the non-architectural tags, pushes compacted at tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PHYS_W'(NUM_ARCH + i);
    end else begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (commit_valid_i[k]) mem[wr_ptr[k].idx] <= commit_tag_i[k*PHYS_W +: PHYS_W];
      end
    end
  end

  fl_ckpt_table #(.NUM_CKPT(NUM_CKPT)) u_ckpt (
    .clk          (clk),
    .reset        (reset),
    .clear_all    (recover_i),
    .alloc        (ckpt_ok_o),
    .alloc_head   (head_next),
    .alloc_id     (ckpt_id_o),
    .full         (ckpt_full),
    .release_mask (ckpt_release_i),
    .restore      (restore_i && !recover_i),
    .restore_id   (restore_id_i),
    .restore_head (restore_head),
    .restore_valid(restore_valid)
  );

`ifdef FREELIST_STATS_EN
  logic [31:0] stall_cycles_reg;
  logic [15:0] restore_cnt_reg;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      restore_cnt_reg  <= '0;
    end else begin
      if ((|alloc_req_i) && empty_o && !stall_i && stall_cycles_reg != '1)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if (restore_i && restore_cnt_reg != '1)
        restore_cnt_reg <= restore_cnt_reg + 16'd1;
    end
  end

  assign stall_cycles_o = stall_cycles_reg;
  assign restore_cnt_o  = restore_cnt_reg;
`endif

endmodule

// File: tb/tb_ckpt_free_list.sv
// Directed self-checking bench for ckpt_free_list.
module tb_ckpt_free_list;
  import rename_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic [3:0]  alloc_req_i;
  logic [27:0] alloc_tag_o;
  logic        alloc_ok_o;
  logic        empty_o;
  logic [3:0]  commit_valid_i;
  logic [27:0] commit_tag_i;
  logic        ckpt_req_i;
  logic [2:0]  ckpt_id_o;
  logic        ckpt_ok_o;
  logic        ckpt_full_o;
  logic        restore_i;
  logic [2:0]  restore_id_i;
  logic [7:0]  ckpt_release_i;
  logic        recover_i;
  logic        overflow_o;
`ifdef FREELIST_STATS_EN
  logic [31:0] stall_cycles_o;
  logic [15:0] restore_cnt_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ckpt_free_list dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .alloc_req_i   (alloc_req_i),
    .alloc_tag_o   (alloc_tag_o),
    .alloc_ok_o    (alloc_ok_o),
    .empty_o       (empty_o),
    .commit_valid_i(commit_valid_i),
    .commit_tag_i  (commit_tag_i),
    .ckpt_req_i    (ckpt_req_i),
    .ckpt_id_o     (ckpt_id_o),
    .ckpt_ok_o     (ckpt_ok_o),
    .ckpt_full_o   (ckpt_full_o),
    .restore_i     (restore_i),
    .restore_id_i  (restore_id_i),
    .ckpt_release_i(ckpt_release_i),
    .recover_i     (recover_i),
`ifdef FREELIST_STATS_EN
    .stall_cycles_o(stall_cycles_o),
    .restore_cnt_o (restore_cnt_o),
`endif
    .overflow_o    (overflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lane(input int k);
    return 32'(alloc_tag_o[k*7 +: 7]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; alloc_req_i = 0; commit_valid_i = 0; commit_tag_i = 0;
    ckpt_req_i = 0; restore_i = 0; restore_id_i = 0; ckpt_release_i = 0; recover_i = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick();
    tick();
    reset = 0;
    #1;

    // 1. Reset state and first allocations
    chk("rst_empty", 32'(empty_o), 0);
    chk("rst_ovf", 32'(overflow_o), 0);
    chk("rst_ok", 32'(alloc_ok_o), 0);
    chk("rst_full", 32'(ckpt_full_o), 0);
    chk("rst_count", 32'(dut.count_reg), 64);
    alloc_req_i = 4'b1111; #1;
    chk("a1_ok", 32'(alloc_ok_o), 1);
    chk("a1_l0", lane(0), 32); chk("a1_l1", lane(1), 33);
    chk("a1_l2", lane(2), 34); chk("a1_l3", lane(3), 35);
    stall_i = 1; #1;
    chk("stall_ok", 32'(alloc_ok_o), 0);
    stall_i = 0;
    tick();
    chk("a1_count", 32'(dut.count_reg), 60);
    alloc_req_i = 4'b0101; #1;
    chk("a2_l0", lane(0), 36); chk("a2_l1", lane(1), 0);
    chk("a2_l2", lane(2), 37); chk("a2_l3", lane(3), 0);
    tick();
    chk("a2_count", 32'(dut.count_reg), 58);

    // 2. Drain to 3, denied, then a push refills
    do_reset();
    alloc_req_i = 4'b1111;
    for (int i = 0; i < 15; i++) tick();
    alloc_req_i = 4'b0001;
    tick();
    chk("dr_count", 32'(dut.count_reg), 3);
    #1;
    chk("dr_ok", 32'(alloc_ok_o), 0);
    chk("dr_empty", 32'(empty_o), 1);
    tick();
    chk("dr_head", 32'(dut.head_reg), 61);
    alloc_req_i = 0; commit_valid_i = 4'b0100; commit_tag_i = 28'(7) << 14;
    tick();
    commit_valid_i = 0; commit_tag_i = 0;
    chk("dr_count4", 32'(dut.count_reg), 4);
    alloc_req_i = 4'b0001; #1;
    chk("dr_ok2", 32'(alloc_ok_o), 1);
    chk("dr_tag", lane(0), 93);
    tick();

    // 3. Checkpoint with same-cycle alloc, then restore
    do_reset();
    alloc_req_i = 4'b1111; tick();
    alloc_req_i = 4'b0011; ckpt_req_i = 1; #1;
    chk("ck_ok", 32'(ckpt_ok_o), 1);
    chk("ck_id", 32'(ckpt_id_o), 0);
    tick();
    ckpt_req_i = 0; alloc_req_i = 4'b1111;
    tick(); tick();
    chk("ck_count", 32'(dut.count_reg), 50);
    alloc_req_i = 0; restore_i = 1; restore_id_i = 0;
    tick();
    restore_i = 0;
    chk("rs_head", 32'(dut.head_reg), 6);
    chk("rs_count", 32'(dut.count_reg), 58);
    ckpt_req_i = 1; alloc_req_i = 4'b0001; #1;
    chk("rs_free_id", 32'(ckpt_id_o), 0);
    chk("rs_free_ok", 32'(ckpt_ok_o), 1);
    chk("rs_tag", lane(0), 38);
    tick();
    idle();

    // Restore of an unallocated slot is ignored
    do_reset();
    restore_i = 1; restore_id_i = 3;
    tick();
    restore_i = 0;
    chk("rsu_head", 32'(dut.head_reg), 0);
    chk("rsu_count", 32'(dut.count_reg), 64);

    // 4. Fill all slots, release and regrant
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ckpt_req_i = 1; #1;
      chk("fill_ok", 32'(ckpt_ok_o), 1);
      chk("fill_id", 32'(ckpt_id_o), 32'(i));
      tick();
    end
    ckpt_req_i = 1; ckpt_release_i = 8'h04; #1;
    chk("full_flag", 32'(ckpt_full_o), 1);
    chk("full_ok", 32'(ckpt_ok_o), 0);
    tick();
    ckpt_release_i = 0; #1;
    chk("rel_ok", 32'(ckpt_ok_o), 1);
    chk("rel_id", 32'(ckpt_id_o), 2);
    tick();
    ckpt_req_i = 0; #1;
    chk("refull", 32'(ckpt_full_o), 1);

    // 5. Wrap with balanced alloc/commit, then recover
    do_reset();
    for (int i = 0; i < 17; i++) begin
      alloc_req_i = 4'b1111; commit_valid_i = 4'b1111;
      commit_tag_i = {7'd4, 7'd3, 7'd2, 7'd1};
      #1;
      if (i == 16) begin
        chk("wr_l0", lane(0), 1);
        chk("wr_l3", lane(3), 4);
      end
      tick();
      if (i == 15) chk("wr_tail", 32'(dut.tail_reg), 32'h40);
    end
    chk("wr_count", 32'(dut.count_reg), 64);
    chk("wr_head", 32'(dut.head_reg), 32'h44);
    commit_valid_i = 0; commit_tag_i = 0;
    tick(); tick();
    chk("wr_count56", 32'(dut.count_reg), 56);
    alloc_req_i = 4'b1111; recover_i = 1; commit_valid_i = 4'b0001; commit_tag_i = 28'd9;
    #1;
    chk("rc_ok", 32'(alloc_ok_o), 0);
    tick();
    idle();
    chk("rc_count", 32'(dut.count_reg), 64);
    chk("rc_head", 32'(dut.head_reg), 32'h45);
    chk("rc_tail", 32'(dut.tail_reg), 32'h45);

    // 6. Overflow is sticky until reset
    do_reset();
    commit_valid_i = 4'b0001; commit_tag_i = 28'd5;
    tick();
    idle();
    chk("ov_set", 32'(overflow_o), 1);
    chk("ov_count", 32'(dut.count_reg), 64);
    tick(); tick();
    chk("ov_sticky", 32'(overflow_o), 1);
    do_reset();
    chk("ov_clr", 32'(overflow_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
